// File: rtl/axis_pkt_arbiter_rr.sv
// Packet-granular round-robin N-to-1 AXI4-Stream merger with a registered skid output stage.
// Optional per-channel packet counters are enabled with ARB_PKT_CNT_EN.
module axis_pkt_arbiter_rr #(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned DATA_BITS = 512,
  parameter int unsigned ID_BITS   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic [N_CH-1:0]                   s_tvalid,
  output logic [N_CH-1:0]                   s_tready,
  input  logic [N_CH*DATA_BITS-1:0]         s_tdata,
  input  logic [N_CH*(DATA_BITS/8)-1:0]     s_tkeep,
  input  logic [N_CH-1:0]                   s_tlast,
  output logic                              m_tvalid,
  input  logic                              m_tready,
  output logic [DATA_BITS-1:0]              m_tdata,
  output logic [(DATA_BITS/8)-1:0]          m_tkeep,
  output logic                              m_tlast,
  output logic [ID_BITS-1:0]                m_tid
`ifdef ARB_PKT_CNT_EN
  ,
  output logic [N_CH*32-1:0]                pkt_cnt
`endif
);

  localparam int unsigned KEEP_BITS = DATA_BITS / 8;

  typedef enum logic {ARB, XFER} state_t;

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic [KEEP_BITS-1:0] keep;
    logic                 last;
    logic [ID_BITS-1:0]   id;
  } beat_t;

  state_t             state, nxt_state;
  logic [ID_BITS-1:0] ptr, nxt_ptr;
  logic [ID_BITS-1:0] grant, nxt_grant;
  beat_t              main_q, skid_q, nxt_main, nxt_skid, in_beat;
  logic               main_vld, skid_vld, nxt_main_vld, nxt_skid_vld;
  logic [N_CH-1:0]    nxt_tready;
  logic               accept, pop, found;

  // Only the granted channel can ever have s_tready set.
  assign accept = |(s_tvalid & s_tready);
  assign pop    = main_vld & m_tready;

  // Select the granted channel's payload, tagged with its index.
  always_comb begin
    in_beat    = '0;
    in_beat.id = grant;
    for (int i = 0; i < N_CH; i++) begin
      if (grant == ID_BITS'(i)) begin
        in_beat.data = s_tdata[i*DATA_BITS +: DATA_BITS];
        in_beat.keep = s_tkeep[i*KEEP_BITS +: KEEP_BITS];
        in_beat.last = s_tlast[i];
      end
    end
  end

  // Next state: arbitration, packet tracking, skid buffer and ready.
  always_comb begin
    nxt_state    = state;
    nxt_ptr      = ptr;
    nxt_grant    = grant;
    nxt_main     = main_q;
    nxt_main_vld = main_vld;
    nxt_skid     = skid_q;
    nxt_skid_vld = skid_vld;
    nxt_tready   = '0;
    found        = 1'b0;

    case (state)
      ARB: begin
        // Search ptr..N_CH-1 first, then wrap to 0..ptr-1.
        for (int j = 0; j < N_CH; j++) begin
          if (!found && s_tvalid[j] && (ID_BITS'(j) >= ptr)) begin
            found     = 1'b1;
            nxt_grant = ID_BITS'(j);
          end
        end
        for (int j = 0; j < N_CH; j++) begin
          if (!found && s_tvalid[j]) begin
            found     = 1'b1;
            nxt_grant = ID_BITS'(j);
          end
        end
        if (found) nxt_state = XFER;
      end
      XFER: begin
        if (accept && in_beat.last) begin
          nxt_state = ARB;
          nxt_ptr   = (grant == ID_BITS'(N_CH - 1)) ? '0 : grant + ID_BITS'(1);
        end
      end
      default: nxt_state = ARB;
    endcase

    if (skid_vld) begin
      if (pop) begin
        nxt_main     = skid_q;
        nxt_main_vld = 1'b1;
        nxt_skid_vld = 1'b0;
      end
    end else if (accept) begin
      if (!main_vld || m_tready) begin
        nxt_main     = in_beat;
        nxt_main_vld = 1'b1;
      end else begin
        nxt_skid     = in_beat;
        nxt_skid_vld = 1'b1;
      end
    end else if (pop) begin
      nxt_main_vld = 1'b0;
    end

    for (int j = 0; j < N_CH; j++) begin
      nxt_tready[j] = (nxt_state == XFER) && !nxt_skid_vld && (nxt_grant == ID_BITS'(j));
    end
  end

  // FSM state register.
  always_ff @(posedge aclk) begin
    if (areset) state <= ARB;
    else        state <= nxt_state;
  end

  // Arbitration and output-stage registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      ptr      <= '0;
      grant    <= '0;
      main_q   <= '0;
      main_vld <= 1'b0;
      skid_q   <= '0;
      skid_vld <= 1'b0;
      s_tready <= '0;
    end else begin
      ptr      <= nxt_ptr;
      grant    <= nxt_grant;
      main_q   <= nxt_main;
      main_vld <= nxt_main_vld;
      skid_q   <= nxt_skid;
      skid_vld <= nxt_skid_vld;
      s_tready <= nxt_tready;
    end
  end

  assign m_tvalid = main_vld;
  assign m_tdata  = main_q.data;
  assign m_tkeep  = main_q.keep;
  assign m_tlast  = main_q.last;
  assign m_tid    = main_q.id;

`ifdef ARB_PKT_CNT_EN
  // Count accepted end-of-packet beats per source channel.
  always_ff @(posedge aclk) begin
    if (areset) begin
      pkt_cnt <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (accept && in_beat.last && (grant == ID_BITS'(i))) begin
          pkt_cnt[i*32 +: 32] <= pkt_cnt[i*32 +: 32] + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_axis_pkt_arbiter_rr.sv
// Scoreboard bench for axis_pkt_arbiter_rr: per-channel packet queues, round-robin order
// expectations and directed timing checks around backpressure, single beats and reset.
module tb_axis_pkt_arbiter_rr;

  localparam int NC = 4;
  localparam int DW = 32;
  localparam int KW = DW / 8;
  localparam int IW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } tb_beat_t;

  logic             aclk;
  logic             areset;
  logic [NC-1:0]    s_tvalid;
  logic [NC-1:0]    s_tready;
  logic [NC*DW-1:0] s_tdata;
  logic [NC*KW-1:0] s_tkeep;
  logic [NC-1:0]    s_tlast;
  logic             m_tvalid;
  logic             m_tready;
  logic [DW-1:0]    m_tdata;
  logic [KW-1:0]    m_tkeep;
  logic             m_tlast;
  logic [IW-1:0]    m_tid;
`ifdef ARB_PKT_CNT_EN
  logic [NC*32-1:0] pkt_cnt;
  int               exp_cnt [NC] = '{5, 0, 0, 3};
`endif

  axis_pkt_arbiter_rr #(.N_CH(NC), .DATA_BITS(DW), .ID_BITS(IW)) dut (
`ifdef ARB_PKT_CNT_EN
    .pkt_cnt (pkt_cnt),
`endif
    .aclk    (aclk),
    .areset  (areset),
    .s_tvalid(s_tvalid),
    .s_tready(s_tready),
    .s_tdata (s_tdata),
    .s_tkeep (s_tkeep),
    .s_tlast (s_tlast),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .m_tdata (m_tdata),
    .m_tkeep (m_tkeep),
    .m_tlast (m_tlast),
    .m_tid   (m_tid)
  );

  tb_beat_t    src_q [NC][$];
  tb_beat_t    exp_q [NC][$];
  int          exp_tid_q[$];
  int unsigned gap_pct [NC];
  int          mready_mode;
  int          checks;
  int          errors;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_pkt(input int ch, input int len, input logic [DW-1:0] base, input bit fixed);
    tb_beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = fixed ? base + DW'(k) : DW'($urandom);
      b.keep = fixed ? '1 : KW'($urandom);
      b.last = (k == len - 1);
      src_q[ch].push_back(b);
      exp_q[ch].push_back(b);
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    int r = 1;
    while (r != 0 && n < budget) begin
      @(negedge aclk);
      n++;
      r = exp_tid_q.size() + int'(m_tvalid);
      for (int c = 0; c < NC; c++) r += exp_q[c].size();
    end
    check(name, 64'(r), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge aclk); #2 areset = 1'b1;
    repeat (2) @(posedge aclk);
    #2 areset = 1'b0;
    @(negedge aclk);
  endtask

  // Source driver: presents queued beats, holds valid until accepted, optional mid-packet gaps.
  initial begin
    logic [NC-1:0] hs;
    logic [NC-1:0] in_pkt;
    tb_beat_t      b;
    s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0; m_tready = 1'b1;
    in_pkt = '0;
    forever begin
      @(negedge aclk);
      hs = s_tvalid & s_tready;
      @(posedge aclk);
      #1;
      if (areset) begin
        for (int c = 0; c < NC; c++) begin
          src_q[c].delete();
          exp_q[c].delete();
        end
        exp_tid_q.delete();
        s_tvalid = '0;
        in_pkt   = '0;
      end else begin
        for (int c = 0; c < NC; c++) begin
          if (hs[c]) begin
            b = src_q[c].pop_front();
            in_pkt[c] = !b.last;
          end
          if (!(s_tvalid[c] && !hs[c])) begin
            if (src_q[c].size() > 0 && !(in_pkt[c] && ($urandom_range(99) < gap_pct[c]))) begin
              b = src_q[c][0];
              s_tvalid[c]          = 1'b1;
              s_tdata[c*DW +: DW]  = b.data;
              s_tkeep[c*KW +: KW]  = b.keep;
              s_tlast[c]           = b.last;
            end else begin
              s_tvalid[c] = 1'b0;
            end
          end
        end
      end
      case (mready_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = 1'b0;
        default: m_tready = ($urandom_range(99) < 70);
      endcase
    end
  end

  // Monitor: every output beat must be the next expected beat of its tid's channel.
  initial begin
    bit       mon_active = 0;
    int       mon_ch = 0;
    int       ch;
    tb_beat_t e;
    forever begin
      @(negedge aclk);
      if (areset) begin
        mon_active = 0;
      end else if (m_tvalid && m_tready) begin
        ch = int'(m_tid);
        if (!mon_active) begin
          if (exp_tid_q.size() > 0) check("tid_order", 64'(ch), 64'(exp_tid_q.pop_front()));
          mon_active = 1;
          mon_ch     = ch;
        end else begin
          check("tid_stable", 64'(ch), 64'(mon_ch));
        end
        if (exp_q[ch].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got beat on tid %0d data %0h required none", ch, m_tdata);
        end else begin
          e = exp_q[ch].pop_front();
          check("beat", 64'({m_tdata, m_tkeep, m_tlast}), 64'({e.data, e.keep, e.last}));
        end
        if (m_tlast) mon_active = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    int            n;
    int            acc;
    logic [DW-1:0] d0;
    logic [35:0]   pat, exp_pat;
    checks = 0; errors = 0; mready_mode = 0;
    for (int c = 0; c < NC; c++) gap_pct[c] = 0;
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    #2 areset = 1'b0;
    @(negedge aclk);

    check("rst_mvalid", 64'(m_tvalid), 64'd0);
    check("rst_tready", 64'(s_tready), 64'd0);
    check("rst_mdata",  64'(m_tdata),  64'd0);
    check("rst_mkeep",  64'(m_tkeep),  64'd0);
    check("rst_mlast",  64'(m_tlast),  64'd0);
    check("rst_mtid",   64'(m_tid),    64'd0);

    // Single channel 2, 3-beat packet 0xA,0xB,0xC.
    send_pkt(2, 3, 32'hA, 1);
    @(negedge aclk); check("t1_tready_idle", 64'(s_tready), 64'd0);
    @(negedge aclk); check("t1_tready_rise", 64'(s_tready), 64'h4);
    check("t1_mvalid_early", 64'(m_tvalid), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      check("t1_mvalid", 64'(m_tvalid), 64'd1);
      check("t1_data",   64'(m_tdata), 64'(32'hA + k));
      check("t1_tid",    64'(m_tid), 64'd2);
      check("t1_last",   64'(m_tlast), 64'(k == 2));
    end
    @(negedge aclk); check("t1_mvalid_end", 64'(m_tvalid), 64'd0);
    drain("t1_drain", 50);

    // All channels valid with 2-beat packets: round robin from 0 with an idle cycle per packet.
    do_reset();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < NC; c++) begin
        send_pkt(c, 2, 0, 0);
        exp_tid_q.push_back(c);
      end
    n = 0;
    while (!m_tvalid && n < 20) begin @(negedge aclk); n++; end
    check("t2_start", 64'(m_tvalid), 64'd1);
    for (int k = 0; k < 36; k++) begin
      pat[k]     = m_tvalid;
      exp_pat[k] = (k % 3 != 2);
      @(negedge aclk);
    end
    check("t2_pattern", 64'(pat), 64'(exp_pat));
    drain("t2_drain", 50);

    // Channel 1 stalls mid-packet while channel 0 waits.
    gap_pct[1] = 60;
    send_pkt(1, 4, 0, 0); exp_tid_q.push_back(1);
    repeat (2) @(negedge aclk);
    send_pkt(0, 2, 0, 0); exp_tid_q.push_back(0);
    drain("t3_drain", 200);
    gap_pct[1] = 0;

    // Backpressure: only two beats buffered while m_tready is low.
    mready_mode = 1;
    send_pkt(0, 6, 0, 0);
    d0  = exp_q[0][0].data;
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      if (s_tvalid[0] && s_tready[0]) acc++;
    end
    check("t4_accepts",    64'(acc), 64'd2);
    check("t4_tready_low", 64'(s_tready), 64'd0);
    check("t4_hold_valid", 64'(m_tvalid), 64'd1);
    check("t4_hold_data",  64'(m_tdata), 64'(d0));
    mready_mode = 0;
    drain("t4_drain", 100);

    // Single-beat packet returns to arbitration immediately.
    send_pkt(2, 1, 0, 0);
    @(negedge aclk); check("t5_tready_idle", 64'(s_tready), 64'd0);
    @(negedge aclk); check("t5_tready_rise", 64'(s_tready), 64'h4);
    @(negedge aclk); check("t5_single_arb", 64'(s_tready), 64'd0);
    check("t5_single_out", 64'({m_tvalid, m_tlast, m_tid}), 64'({1'b1, 1'b1, 2'd2}));
    drain("t5_drain", 50);

    // Reset during beat 2 of a 4-beat packet; afterwards ptr must restart at 0.
    send_pkt(0, 4, 0, 0);
    repeat (3) @(negedge aclk);
    @(posedge aclk); #2 areset = 1'b1;
    @(posedge aclk); #2 areset = 1'b0;
    @(negedge aclk);
    check("t6_mvalid", 64'(m_tvalid), 64'd0);
    check("t6_tready", 64'(s_tready), 64'd0);
    check("t6_mtid",   64'(m_tid), 64'd0);
    send_pkt(3, 2, 0, 0);
    send_pkt(1, 2, 0, 0);
    exp_tid_q.push_back(1);
    exp_tid_q.push_back(3);
    drain("t6_drain", 100);

    // Randomised traffic with gaps and random backpressure.
    for (int c = 0; c < NC; c++) gap_pct[c] = $urandom_range(40);
    mready_mode = 2;
    repeat (40) send_pkt(int'($urandom_range(NC - 1)), int'($urandom_range(6, 1)), 0, 0);
    drain("rand_drain", 6000);
    mready_mode = 0;
    for (int c = 0; c < NC; c++) gap_pct[c] = 0;

`ifdef ARB_PKT_CNT_EN
    do_reset();
    repeat (5) send_pkt(0, int'($urandom_range(3, 1)), 0, 0);
    repeat (3) send_pkt(3, int'($urandom_range(3, 1)), 0, 0);
    drain("cnt_drain", 200);
    for (int c = 0; c < NC; c++) check("pkt_cnt", 64'(pkt_cnt[c*32 +: 32]), 64'(exp_cnt[c]));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_pkt_arbiter_rr.md
# axis_pkt_arbiter_rr

Packet-aware N-to-1 AXI4-Stream merger with round-robin arbitration at packet (tlast) granularity. It is the parametrised successor of the fixed 2-to-1, 512-bit host/card stream mergers in the ACCL user-logic shell. It generalises channel count and data width and tags each output packet with its source channel on tid. It sits between the per-channel host/card/TCP sink streams and a single ACCL DMA mm2s input, and has a registered, full-throughput output stage.

## Interface
- N_CH, 4: number of input channels; 2..16.
- DATA_BITS, 512: tdata width; a multiple of 8. KEEP_BITS = DATA_BITS/8.
- ID_BITS, $clog2(N_CH) (minimum 1): width of the output tid.

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous reset, active-high
- s_tvalid  in  N_CH  per-channel valid
- s_tready  out  N_CH  per-channel ready
- s_tdata  in  N_CH*DATA_BITS  channel i occupies slice [i*DATA_BITS +: DATA_BITS]
- s_tkeep  in  N_CH*KEEP_BITS  per-channel keep
- s_tlast  in  N_CH  per-channel end-of-packet
- m_tvalid  out  1  merged valid
- m_tready  in  1  merged ready
- m_tdata  out  DATA_BITS  merged data
- m_tkeep  out  KEEP_BITS  merged keep
- m_tlast  out  1  merged tlast
- m_tid  out  ID_BITS  index of the source channel for the current beat
- pkt_cnt  out  N_CH*32  per-channel packet counters; present only with ARB_PKT_CNT_EN

## Operation
- FSM states:
  - ARB: no channel is granted and all s_tready are 0. If any s_tvalid is set, the block registers the grant to the first valid channel found searching upward from ptr, wrapping modulo N_CH, then moves to XFER. If no s_tvalid is set, it stays in ARB.
  - XFER: s_tready[grant] = !skid_full. All other s_tready are 0. A beat transfers on s_tvalid[grant] && s_tready[grant].
  - On a transfer with s_tlast[grant] = 1: ptr <= grant+1 (wrapping N_CH-1 -> 0), then go to ARB.
- Grant is never changed mid-packet. A granted channel that drops s_tvalid holds the grant until it delivers its tlast.
- Output stage: a two-entry skid buffer (main + skid register).
  - The upstream beat moves into main when main is empty or m_tready=1. Otherwise it goes into skid.
  - skid_full deasserts the granted s_tready in the next cycle.
- m_tid is the grant captured together with each beat. It stays stable for the whole packet.
- Data, keep and last pass through unmodified. No tkeep checking is done.

## Timing
- Reset values: state=ARB, ptr=0, grant=0, m_tvalid=0, all s_tready=0, skid empty, m_tdata/m_tkeep/m_tlast/m_tid=0, pkt_cnt=0.
- Arbitration costs exactly one cycle per packet:
  - The first beat of a packet can be accepted no earlier than 1 cycle after ARB samples valid.
  - The minimum cycle count for a P-beat packet is P+1.
- Latency: 1 cycle from input handshake to m_tvalid.
- Within a packet: 1 beat/cycle while m_tready=1.
- m_tdata/m_tkeep/m_tlast/m_tid are held stable while m_tvalid && !m_tready.
- Once asserted, m_tvalid drops only after a handshake with no further data buffered.
- Boundary conditions:
  - Simultaneous valid on all channels: grant order is ptr, ptr+1, …, which is fair with no starvation.
  - Single-beat packets: tlast on the first beat returns the FSM to ARB immediately.
  - m_tready held low: at most 2 beats are buffered, then s_tready[grant]=0.
  - Reset mid-packet: the partial packet is discarded and the output is cleared in the same cycle. Upstream must also reset.

## Configuration
- ARB_PKT_CNT_EN defined:
  - pkt_cnt[i*32 +: 32] increments on every accepted tlast beat from channel i.
  - The counter wraps at 2^32 and is cleared by areset.
- ARB_PKT_CNT_EN undefined: the pkt_cnt port and the counter logic are absent.

## Test plan
- Single channel 2 sends a 3-beat packet (data 0xA,0xB,0xC, tlast on 0xC), m_tready=1:
  - s_tready[2] rises 1 cycle after s_tvalid.
  - m_tvalid appears 1 cycle after each accept.
  - m_tid=2 on all 3 beats; tlast only on 0xC.
- N_CH=4, all channels continuously valid with 2-beat packets:
  - Output tid sequence is 0,0,1,1,2,2,3,3,0,…
  - One idle cycle between packets.
- Channel 1 drops s_tvalid mid-packet while channel 0 is valid: the grant stays on 1, and no channel-0 beat appears before the channel-1 tlast.
- m_tready held 0 for 5 cycles during a 6-beat packet:
  - Exactly 2 beats are accepted, then s_tready=0.
  - After release, all 6 beats emerge in order with no loss or duplication.
- areset asserted on beat 2 of a 4-beat packet:
  - Next cycle: m_tvalid=0, s_tready=0, ptr=0.
  - A new packet on channel 3 then arbitrates normally.
- ARB_PKT_CNT_EN defined, 5 packets from channel 0 and 3 from channel 3: pkt_cnt reads 5,0,0,3.
